// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-unit state encoding.
// Imported by the ALU control decoder, main control and execute stage.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } exec_state_e;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Iterative shifter: one bit position per cycle.
// Load performs the first step so a shift by s finishes after s edges.
module alu_shift_seq #(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     step,
    input  logic                     left,
    input  logic                     arith,
    input  logic [XLEN-1:0]          op_a,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    output logic [XLEN-1:0]          nxt,
    output logic                     last
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [XLEN-1:0]    data;
    logic [SHAMT_W-1:0] count;
    logic               left_q;
    logic               arith_q;
    logic [XLEN-1:0]    src;
    logic [XLEN-1:0]    sh;
    logic               l_sel;
    logic               a_sel;

    always_comb begin
        src   = load ? op_a  : data;
        l_sel = load ? left  : left_q;
        a_sel = load ? arith : arith_q;
        if (l_sel) begin
            sh = {src[XLEN-2:0], 1'b0};
        end else begin
            sh = {a_sel & src[XLEN-1], src[XLEN-1:1]};
        end
        nxt = (load && shamt == '0) ? op_a : sh;
    end

    assign last = (count == SHAMT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            count   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (load) begin
            data    <= nxt;
            count   <= (shamt == '0) ? '0 : shamt - SHAMT_W'(1);
            left_q  <= left;
            arith_q <= arith;
        end else if (step) begin
            data  <= nxt;
            count <= count - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts,
// valid/ready on both sides, registered result/zero/illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHAMT_W = $clog2(XLEN);

    exec_state_e        state;
    exec_state_e        state_nxt;
    logic [XLEN-1:0]    alu_res;
    logic               bad_code;
    logic               is_shift;
    logic               long_shift;
    logic               accept;
    logic               step;
    logic               fin;
    logic [XLEN-1:0]    fin_val;
    logic               fin_ill;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    shift_nxt;
    logic               shift_last;

    assign shamt      = op_b[SHAMT_W-1:0];
    assign is_shift   = is_shift_op(alu_ctrl);
    assign long_shift = is_shift && (shamt > SHAMT_W'(1));
    assign accept     = in_valid && in_ready;
    assign step       = (state == ST_SHIFT);
    assign out_valid  = (state == ST_DONE);

    always_comb begin
        alu_res  = '0;
        bad_code = 1'b0;
        unique case (alu_ctrl)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SLT:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU:   alu_res = XLEN'(op_a < op_b);
            ALU_PASS_B: alu_res = op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = '0;
            default:    bad_code = 1'b1;
        endcase
    end

    alu_shift_seq #(
        .XLEN (XLEN)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (accept && is_shift),
        .step  (step),
        .left  (alu_ctrl == ALU_SLL),
        .arith (alu_ctrl == ALU_SRA),
        .op_a  (op_a),
        .shamt (shamt),
        .nxt   (shift_nxt),
        .last  (shift_last)
    );

    // Results land in the output registers on the edge that enters DONE.
    assign fin     = (accept && !long_shift) || (step && shift_last);
    assign fin_val = (step || is_shift) ? shift_nxt : alu_res;
    assign fin_ill = !step && bad_code;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = long_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (shift_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt = long_shift ? ST_SHIFT : ST_DONE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fin) begin
                result  <= fin_val;
                zero    <= (fin_val == '0);
                illegal <= fin_ill;
            end
        end
    end

endmodule
